// File: rtl/line_raster_ctrl_if.sv
// ----------------------------------------------------------------------------
// line_raster_ctrl_if
// Purpose : groups every non-clock signal of the line raster controller:
//           the command request side, the line generator side and the
//           downstream pixel writer side.
// Modports: slave  - the controller's view (commands, generator status and
//                    pixel acks in; endpoints, strobes and pixels out)
//           master - the environment's view (the reverse directions)
// Signals :
//   write_i, dest_pixel0/1_x/y_i      command request and endpoints
//   ack_o, busy_o                     command finished pulse / in progress
//   pixel0/1_x/y_o, delta_*_o,        normalized line to the generator
//   x_major_o, minor_slope_positive_o
//   draw_line_o, read_pixel_o         generator load / step strobes
//   line_busy_i, major_i, minor_i     generator status and current point
//   x_o, y_o, write_o, ack_i          pixel to / accept from the writer
// ----------------------------------------------------------------------------
interface line_raster_ctrl_if;
  logic        write_i;
  logic [15:0] dest_pixel0_x_i;
  logic [15:0] dest_pixel0_y_i;
  logic [15:0] dest_pixel1_x_i;
  logic [15:0] dest_pixel1_y_i;
  logic        ack_o;
  logic        busy_o;
  logic [15:0] pixel0_x_o;
  logic [15:0] pixel0_y_o;
  logic [15:0] pixel1_x_o;
  logic [15:0] pixel1_y_o;
  logic [15:0] delta_major_o;
  logic [15:0] delta_minor_o;
  logic        x_major_o;
  logic        minor_slope_positive_o;
  logic        draw_line_o;
  logic        read_pixel_o;
  logic        line_busy_i;
  logic [15:0] major_i;
  logic [15:0] minor_i;
  logic [15:0] x_o;
  logic [15:0] y_o;
  logic        write_o;
  logic        ack_i;

  modport slave (
    input  write_i, dest_pixel0_x_i, dest_pixel0_y_i,
           dest_pixel1_x_i, dest_pixel1_y_i,
           line_busy_i, major_i, minor_i, ack_i,
    output ack_o, busy_o, pixel0_x_o, pixel0_y_o, pixel1_x_o, pixel1_y_o,
           delta_major_o, delta_minor_o, x_major_o, minor_slope_positive_o,
           draw_line_o, read_pixel_o, x_o, y_o, write_o
  );

  modport master (
    output write_i, dest_pixel0_x_i, dest_pixel0_y_i,
           dest_pixel1_x_i, dest_pixel1_y_i,
           line_busy_i, major_i, minor_i, ack_i,
    input  ack_o, busy_o, pixel0_x_o, pixel0_y_o, pixel1_x_o, pixel1_y_o,
           delta_major_o, delta_minor_o, x_major_o, minor_slope_positive_o,
           draw_line_o, read_pixel_o, x_o, y_o, write_o
  );
endinterface

// File: rtl/line_raster_ctrl.sv
// ----------------------------------------------------------------------------
// line_raster_ctrl
// Purpose : accepts a line command (two signed 16-bit endpoints), normalizes
//           it for a Bresenham-style line generator (major axis selection,
//           endpoint swap so the minor coordinate never decreases, absolute
//           deltas), loads the generator, then forwards each generated pixel
//           to a downstream writer with a valid/ack handshake, stepping the
//           generator after every accepted pixel until it reports idle.
// Ports   : clk_i  - clock, rising edge
//           rst_i  - asynchronous reset, active low
//           bus    - line_raster_ctrl_if.slave (command, generator and
//                    pixel writer signals)
// ----------------------------------------------------------------------------
module line_raster_ctrl (
  input  logic clk_i,
  input  logic rst_i,
  line_raster_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    EMIT  = 3'd3,
    STEP  = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6
  } state_e;

  state_e state_q, state_d;

  // Raw command endpoints captured in IDLE
  logic [15:0] x0_q, y0_q, x1_q, y1_q;
  logic [15:0] x0_d, y0_d, x1_d, y1_d;

  // Normalized line handed to the generator
  logic [15:0] p0x_q, p0y_q, p1x_q, p1y_q;
  logic [15:0] p0x_d, p0y_d, p1x_d, p1y_d;
  logic [15:0] deltaMajor_q, deltaMinor_q;
  logic [15:0] deltaMajor_d, deltaMinor_d;
  logic        xMajor_q, slopePos_q;
  logic        xMajor_d, slopePos_d;

  // Setup arithmetic (17 bits so the difference of two 16-bit signed values
  // cannot overflow)
  logic [16:0] dx, dy, absDx, absDy, majD, minD;
  logic        xMajorC, swapC, slopePosC;

  // Output decode
  logic        drawLine, readPixel, writePix, ackPulse;
  logic [15:0] xOut, yOut;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.write_i)      state_d = SETUP;
      SETUP:   if (!bus.line_busy_i) state_d = LOAD;
      LOAD:                          state_d = EMIT;
      EMIT:    if (bus.ack_i)        state_d = STEP;
      STEP:                          state_d = CHECK;
      CHECK:   state_d = bus.line_busy_i ? EMIT : DONE;
      DONE:                          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Output logic: strobes decode from state only; the pixel mux is only
  // driven while a pixel is actually offered
  always_comb begin
    drawLine  = 1'b0;
    readPixel = 1'b0;
    writePix  = 1'b0;
    ackPulse  = 1'b0;
    xOut      = 16'd0;
    yOut      = 16'd0;
    case (state_q)
      LOAD: drawLine  = 1'b1;
      EMIT: begin
        writePix = 1'b1;
        xOut     = xMajor_q ? bus.major_i : bus.minor_i;
        yOut     = xMajor_q ? bus.minor_i : bus.major_i;
      end
      STEP: readPixel = 1'b1;
      DONE: ackPulse  = 1'b1;
      default: ;
    endcase
  end

  // Line normalization. The endpoints are swapped whenever the minor delta
  // is negative, so the generator only ever increments the minor axis; the
  // major direction then comes from the sign of the (negated) major delta.
  always_comb begin
    dx        = {x1_q[15], x1_q} - {x0_q[15], x0_q};
    dy        = {y1_q[15], y1_q} - {y0_q[15], y0_q};
    absDx     = dx[16] ? (17'd0 - dx) : dx;
    absDy     = dy[16] ? (17'd0 - dy) : dy;
    xMajorC   = (absDx >= absDy);
    majD      = xMajorC ? dx : dy;
    minD      = xMajorC ? dy : dx;
    swapC     = minD[16];
    slopePosC = swapC ? (majD[16] || (majD == 17'd0)) : !majD[16];
  end

  // Register next-state: capture endpoints in IDLE, recompute the
  // normalized line on every SETUP cycle, hold everything otherwise
  always_comb begin
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    p0x_d        = p0x_q;
    p0y_d        = p0y_q;
    p1x_d        = p1x_q;
    p1y_d        = p1y_q;
    deltaMajor_d = deltaMajor_q;
    deltaMinor_d = deltaMinor_q;
    xMajor_d     = xMajor_q;
    slopePos_d   = slopePos_q;
    if (state_q == IDLE && bus.write_i) begin
      x0_d = bus.dest_pixel0_x_i;
      y0_d = bus.dest_pixel0_y_i;
      x1_d = bus.dest_pixel1_x_i;
      y1_d = bus.dest_pixel1_y_i;
    end
    if (state_q == SETUP) begin
      p0x_d        = swapC ? x1_q : x0_q;
      p0y_d        = swapC ? y1_q : y0_q;
      p1x_d        = swapC ? x0_q : x1_q;
      p1y_d        = swapC ? y0_q : y1_q;
      deltaMajor_d = xMajorC ? absDx[15:0] : absDy[15:0];
      deltaMinor_d = xMajorC ? absDy[15:0] : absDx[15:0];
      xMajor_d     = xMajorC;
      slopePos_d   = slopePosC;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x0_q         <= 16'd0;
      y0_q         <= 16'd0;
      x1_q         <= 16'd0;
      y1_q         <= 16'd0;
      p0x_q        <= 16'd0;
      p0y_q        <= 16'd0;
      p1x_q        <= 16'd0;
      p1y_q        <= 16'd0;
      deltaMajor_q <= 16'd0;
      deltaMinor_q <= 16'd0;
      xMajor_q     <= 1'b0;
      slopePos_q   <= 1'b0;
    end else begin
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      p0x_q        <= p0x_d;
      p0y_q        <= p0y_d;
      p1x_q        <= p1x_d;
      p1y_q        <= p1y_d;
      deltaMajor_q <= deltaMajor_d;
      deltaMinor_q <= deltaMinor_d;
      xMajor_q     <= xMajor_d;
      slopePos_q   <= slopePos_d;
    end
  end

  assign bus.pixel0_x_o             = p0x_q;
  assign bus.pixel0_y_o             = p0y_q;
  assign bus.pixel1_x_o             = p1x_q;
  assign bus.pixel1_y_o             = p1y_q;
  assign bus.delta_major_o          = deltaMajor_q;
  assign bus.delta_minor_o          = deltaMinor_q;
  assign bus.x_major_o              = xMajor_q;
  assign bus.minor_slope_positive_o = slopePos_q;
  assign bus.draw_line_o            = drawLine;
  assign bus.read_pixel_o           = readPixel;
  assign bus.write_o                = writePix;
  assign bus.ack_o                  = ackPulse;
  assign bus.x_o                    = xOut;
  assign bus.y_o                    = yOut;
  assign bus.busy_o                 = (state_q != IDLE);

endmodule

// File: tb/tb_line_raster_ctrl.sv
// ----------------------------------------------------------------------------
// tb_line_raster_ctrl
// Purpose : self-checking bench for line_raster_ctrl. Contains a small
//           Bresenham line generator model driving the generator inputs and
//           acts as the downstream pixel writer.
// ----------------------------------------------------------------------------
module tb_line_raster_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  line_raster_ctrl_if bus ();

  line_raster_ctrl dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]       x0, y0, x1, y1;
    logic              xm, sp;
    logic [15:0]       dM, dm;
    logic [15:0]       p0x, p0y, p1x, p1y;
    int                n;
    logic [0:7][15:0]  ex;
    logic [0:7][15:0]  ey;
  } vec_t;

  vec_t vecs[6];

  // Line generator model: loads on draw_line_o, advances one Bresenham step
  // on read_pixel_o and drops busy when stepped past the last pixel
  int   gMaj, gMin, gErr, gRem, gDmaj, gDmin;
  logic gSp;

  assign bus.major_i = gMaj[15:0];
  assign bus.minor_i = gMin[15:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.line_busy_i <= 1'b0;
      gMaj <= 0; gMin <= 0; gErr <= 0; gRem <= 0; gDmaj <= 0; gDmin <= 0;
      gSp  <= 1'b0;
    end else if (bus.draw_line_o) begin
      gMaj  <= bus.x_major_o ? int'($signed(bus.pixel0_x_o)) : int'($signed(bus.pixel0_y_o));
      gMin  <= bus.x_major_o ? int'($signed(bus.pixel0_y_o)) : int'($signed(bus.pixel0_x_o));
      gDmaj <= int'(bus.delta_major_o);
      gDmin <= int'(bus.delta_minor_o);
      gErr  <= 2 * int'(bus.delta_minor_o) - int'(bus.delta_major_o);
      gRem  <= int'(bus.delta_major_o);
      gSp   <= bus.minor_slope_positive_o;
      bus.line_busy_i <= 1'b1;
    end else if (bus.read_pixel_o) begin
      if (gRem == 0) begin
        bus.line_busy_i <= 1'b0;
      end else begin
        if (gErr > 0) begin
          gMin <= gMin + 1;
          gErr <= gErr - 2 * gDmaj + 2 * gDmin;
        end else begin
          gErr <= gErr + 2 * gDmin;
        end
        gMaj <= gSp ? gMaj + 1 : gMaj - 1;
        gRem <= gRem - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setVec(input int i,
                        input logic [15:0] x0, y0, x1, y1,
                        input logic xm, sp,
                        input logic [15:0] dM, dm,
                        input logic [15:0] p0x, p0y, p1x, p1y,
                        input int n,
                        input logic [0:7][15:0] ex, ey);
    vecs[i].x0 = x0;   vecs[i].y0 = y0;   vecs[i].x1 = x1;   vecs[i].y1 = y1;
    vecs[i].xm = xm;   vecs[i].sp = sp;   vecs[i].dM = dM;   vecs[i].dm = dm;
    vecs[i].p0x = p0x; vecs[i].p0y = p0y; vecs[i].p1x = p1x; vecs[i].p1y = p1y;
    vecs[i].n  = n;    vecs[i].ex = ex;   vecs[i].ey = ey;
  endtask

  // Runs one line command. holdCycles keeps ack_i low that many cycles per
  // pixel, pokeWrite pulses write_i during the second pixel, resetAt asserts
  // reset while that pixel index is offered (-1 = never).
  task automatic applyStimulus(input int v, input int holdCycles, input bit pokeWrite, input int resetAt);
    int npix, acks, draws, steps, firstDraw, firstWrite, lastAck, hold, busyDrop;
    logic [15:0] heldX, heldY;
    bit done;
    npix = 0; acks = 0; draws = 0; steps = 0; firstDraw = -1; firstWrite = -1;
    lastAck = -100; hold = 0; busyDrop = 0; done = 0; heldX = '0; heldY = '0;

    @(negedge clk);
    bus.dest_pixel0_x_i = vecs[v].x0;
    bus.dest_pixel0_y_i = vecs[v].y0;
    bus.dest_pixel1_x_i = vecs[v].x1;
    bus.dest_pixel1_y_i = vecs[v].y1;
    bus.write_i = 1'b1;
    @(negedge clk);
    bus.write_i = 1'b0;
    bus.dest_pixel0_x_i = 16'h1234;
    bus.dest_pixel0_y_i = 16'h4321;
    bus.dest_pixel1_x_i = 16'h0F0F;
    bus.dest_pixel1_y_i = 16'hF0F0;

    for (int c = 0; c < 300 && !done; c++) begin
      bus.write_i = 1'b0;
      if (!bus.busy_o) busyDrop++;
      if (bus.draw_line_o) begin
        draws++;
        if (firstDraw < 0) firstDraw = c;
      end
      if (bus.read_pixel_o) steps++;
      if (bus.write_o) begin
        if (firstWrite < 0) firstWrite = c;
        if (resetAt == npix) begin
          rst_n = 1'b0;
          #1;
          checkOutput("reset strobes", {27'd0, bus.write_o, bus.busy_o, bus.draw_line_o,
                                        bus.read_pixel_o, bus.ack_o}, 32'd0);
          checkOutput("reset pixel xy", {bus.x_o, bus.y_o}, 32'd0);
          checkOutput("reset pixel0", {bus.pixel0_x_o, bus.pixel0_y_o}, 32'd0);
          checkOutput("reset pixel1", {bus.pixel1_x_o, bus.pixel1_y_o}, 32'd0);
          checkOutput("reset deltas", {bus.delta_major_o, bus.delta_minor_o}, 32'd0);
          checkOutput("reset flags", {30'd0, bus.x_major_o, bus.minor_slope_positive_o}, 32'd0);
          bus.ack_i = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (pokeWrite && npix == 1) bus.write_i = 1'b1;
        if (hold == 0 && npix > 0)
          checkOutput($sformatf("v%0d gap px%0d", v, npix), {31'd0, (c - lastAck) >= 3}, 32'd1);
        if (hold < holdCycles) begin
          if (hold == 0) begin
            heldX = bus.x_o;
            heldY = bus.y_o;
          end else begin
            checkOutput($sformatf("v%0d hold xy", v), {bus.x_o, bus.y_o}, {heldX, heldY});
            checkOutput($sformatf("v%0d hold read_pixel", v), {31'd0, bus.read_pixel_o}, 32'd0);
          end
          hold++;
          bus.ack_i = 1'b0;
        end else begin
          if (holdCycles > 0)
            checkOutput($sformatf("v%0d hold end xy", v), {bus.x_o, bus.y_o}, {heldX, heldY});
          if (npix < vecs[v].n) begin
            checkOutput($sformatf("v%0d px%0d", v, npix), {bus.x_o, bus.y_o},
                        {vecs[v].ex[npix], vecs[v].ey[npix]});
          end else begin
            checks++;
            errors++;
            $display("[TB] FAIL v%0d extra pixel: got %0h,%0h expected none", v, bus.x_o, bus.y_o);
          end
          npix++;
          bus.ack_i = 1'b1;
          lastAck = c;
          hold = 0;
        end
      end else begin
        // ack_i noise outside EMIT must have no effect
        bus.ack_i = 1'b1;
      end
      if (bus.ack_o) begin
        acks++;
        done = 1;
      end
      @(negedge clk);
    end
    bus.write_i = 1'b0;
    bus.ack_i   = 1'b0;

    checkOutput($sformatf("v%0d ack_o count", v), acks, 1);
    checkOutput($sformatf("v%0d pixel count", v), npix, vecs[v].n);
    checkOutput($sformatf("v%0d draw_line count", v), draws, 1);
    checkOutput($sformatf("v%0d read_pixel count", v), steps, vecs[v].n);
    checkOutput($sformatf("v%0d draw latency", v), firstDraw, 1);
    checkOutput($sformatf("v%0d write latency", v), firstWrite, 2);
    checkOutput($sformatf("v%0d busy drop", v), busyDrop, 0);
    checkOutput($sformatf("v%0d flags", v), {30'd0, bus.x_major_o, bus.minor_slope_positive_o},
                {30'd0, vecs[v].xm, vecs[v].sp});
    checkOutput($sformatf("v%0d deltas", v), {bus.delta_major_o, bus.delta_minor_o},
                {vecs[v].dM, vecs[v].dm});
    checkOutput($sformatf("v%0d pixel0", v), {bus.pixel0_x_o, bus.pixel0_y_o},
                {vecs[v].p0x, vecs[v].p0y});
    checkOutput($sformatf("v%0d pixel1", v), {bus.pixel1_x_o, bus.pixel1_y_o},
                {vecs[v].p1x, vecs[v].p1y});
    checkOutput($sformatf("v%0d idle after", v), {30'd0, bus.busy_o, bus.ack_o}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput($sformatf("v%0d no requeue", v), {30'd0, bus.busy_o, bus.ack_o}, 32'd0);
  endtask

  initial begin
    bus.write_i = 1'b0;
    bus.ack_i   = 1'b0;
    bus.dest_pixel0_x_i = '0;
    bus.dest_pixel0_y_i = '0;
    bus.dest_pixel1_x_i = '0;
    bus.dest_pixel1_y_i = '0;

    //      idx  x0      y0      x1      y1      xm    sp    dM     dm     p0x      p0y      p1x     p1y     n
    setVec(0, 16'd0, 16'd0, 16'd3, 16'd1, 1'b1, 1'b1, 16'd3, 16'd1, 16'd0, 16'd0, 16'd3, 16'd1, 4,
           {16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0},
           {16'd0, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0});
    setVec(1, 16'd5, 16'd5, 16'd5, 16'd5, 1'b1, 1'b1, 16'd0, 16'd0, 16'd5, 16'd5, 16'd5, 16'd5, 1,
           {16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
           {16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
    setVec(2, 16'd2, 16'd0, 16'd0, 16'd6, 1'b0, 1'b0, 16'd6, 16'd2, 16'd0, 16'd6, 16'd2, 16'd0, 7,
           {16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd0},
           {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0});
    setVec(3, 16'd0, 16'd0, 16'hFFFD, 16'hFFFF, 1'b1, 1'b1, 16'd3, 16'd1,
           16'hFFFD, 16'hFFFF, 16'd0, 16'd0, 4,
           {16'hFFFD, 16'hFFFE, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
           {16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
    setVec(4, 16'd1, 16'd1, 16'd2, 16'd1, 1'b1, 1'b1, 16'd1, 16'd0, 16'd1, 16'd1, 16'd2, 16'd1, 2,
           {16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
           {16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
    setVec(5, 16'd0, 16'd0, 16'd1, 16'hFFFD, 1'b0, 1'b0, 16'd3, 16'd1,
           16'd0, 16'd0, 16'd1, 16'hFFFD, 4,
           {16'd0, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0},
           {16'd0, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'd0, 16'd0, 16'd0, 16'd0});

    repeat (3) @(negedge clk);
    checkOutput("reset busy/ack", {30'd0, bus.busy_o, bus.ack_o}, 32'd0);
    checkOutput("reset strobes", {29'd0, bus.write_o, bus.draw_line_o, bus.read_pixel_o}, 32'd0);
    checkOutput("reset deltas", {bus.delta_major_o, bus.delta_minor_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven lines
    for (int v = 0; v < 6; v++) begin
      applyStimulus(v, 0, 1'b0, -1);
    end

    // Downstream stalls for three cycles on every pixel
    applyStimulus(0, 3, 1'b0, -1);

    // write_i pulsed mid-line must not start or queue a second command
    applyStimulus(2, 0, 1'b1, -1);

    // Reset during the third pixel, then a fresh command
    applyStimulus(0, 0, 1'b0, 2);
    checkOutput("post reset idle", {31'd0, bus.busy_o}, 32'd0);
    applyStimulus(4, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
